// File: rtl/tuner_phy_pkg.sv
// Shared types for the tuner PHY blocks.
//   tuner_dac_slew_state_e : state encoding of the ring-tune DAC slew controller,
//                            also exported on its o_state_mon port.
package tuner_phy_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } tuner_dac_slew_state_e;

endpackage

// File: rtl/tuner_dac_slew_ctrl.sv
// Ring-tune DAC slew controller. Sits between the ctrl arbitration stage and
// the AFE DAC. It walks the DAC code toward a requested target in steps of at
// most MAX_STEP and waits SETTLE_CYCLES after every accepted AFE write.
//
// Ports
//   i_clk, i_rst_n        clock, async active-low reset
//   i_tune_val/o_tune_rdy upstream request handshake, i_tune_code = target
//   o_dig_afe_ring_tune   code presented to the AFE DAC
//   o_afe_ring_tune_val   AFE write valid, i_afe_ring_tune_rdy = AFE accept
//   o_tune_done           one-cycle pulse: target reached and settled
//   o_state_mon           current FSM state
//
// state  | meaning
// IDLE   | waiting for a request; only state with o_tune_rdy = 1
// STEP   | AFE write of the next code pending, held until AFE accepts
// SETTLE | counting down settle time after an accepted write
// DONE   | target reached and settled; done pulse for one cycle
module tuner_dac_slew_ctrl
  import tuner_phy_pkg::*;
#(
  parameter int DAC_WIDTH     = 8,
  parameter int MAX_STEP      = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int RESET_CODE    = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_tune_val,
  input  logic [DAC_WIDTH-1:0]  i_tune_code,
  output logic                  o_tune_rdy,
  output logic [DAC_WIDTH-1:0]  o_dig_afe_ring_tune,
  output logic                  o_afe_ring_tune_val,
  input  logic                  i_afe_ring_tune_rdy,
  output logic                  o_tune_done,
  output tuner_dac_slew_state_e o_state_mon
);

  localparam int                   CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]     SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [DAC_WIDTH-1:0] MAX_STEP_C  = DAC_WIDTH'(MAX_STEP);
  localparam logic [DAC_WIDTH-1:0] RESET_C     = DAC_WIDTH'(RESET_CODE);

  tuner_dac_slew_state_e state_q, state_d;
  logic [DAC_WIDTH-1:0]  cur_q, tgt_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  step_up;
  logic [DAC_WIDTH-1:0]  diff, step, next_code;
  logic                  accept;

  // Step size is clamped to the remaining distance, so cur +/- step always
  // lands between cur and tgt: no wrap and no overshoot, even full-scale.
  always_comb begin
    step_up   = tgt_q > cur_q;
    diff      = step_up ? (tgt_q - cur_q) : (cur_q - tgt_q);
    step      = (diff > MAX_STEP_C) ? MAX_STEP_C : diff;
    next_code = step_up ? (cur_q + step) : (cur_q - step);
  end

  // Gated with i_rst_n so upstream never sees ready while reset is held.
  assign o_tune_rdy          = (state_q == IDLE) && i_rst_n;
  assign accept              = i_tune_val && o_tune_rdy;
  assign o_afe_ring_tune_val = (state_q == STEP);
  assign o_dig_afe_ring_tune = (state_q == STEP) ? next_code : cur_q;
  assign o_tune_done         = (state_q == DONE);
  assign o_state_mon         = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (i_tune_code == cur_q) ? DONE : STEP;
      STEP:    if (i_afe_ring_tune_rdy) state_d = SETTLE;
      SETTLE:  if (cnt_q == '0) state_d = (cur_q == tgt_q) ? DONE : STEP;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cur_q   <= RESET_C;
      tgt_q   <= RESET_C;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE:   if (accept) tgt_q <= i_tune_code;
        STEP: begin
          if (i_afe_ring_tune_rdy) begin
            cur_q <= next_code;
            cnt_q <= SETTLE_LOAD;
          end
        end
        SETTLE: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tuner_dac_slew_ctrl.sv
// Self-checking bench for tuner_dac_slew_ctrl. A request-level reference model
// predicts the list of AFE write codes, write/done timing and final code.
module tb_tuner_dac_slew_ctrl;
  import tuner_phy_pkg::*;

  localparam int W  = 8;
  localparam int MS = 4;
  localparam int SC = 8;
  localparam int RC = 0;

  logic                  i_clk = 1'b0;
  logic                  i_rst_n;
  logic                  i_tune_val;
  logic [W-1:0]          i_tune_code;
  logic                  o_tune_rdy;
  logic [W-1:0]          o_dig_afe_ring_tune;
  logic                  o_afe_ring_tune_val;
  logic                  i_afe_ring_tune_rdy;
  logic                  o_tune_done;
  tuner_dac_slew_state_e o_state_mon;

  int n_cmp = 0;
  int n_bad = 0;
  int model_cur = RC;

  always #5 i_clk = ~i_clk;

  tuner_dac_slew_ctrl #(
    .DAC_WIDTH(W), .MAX_STEP(MS), .SETTLE_CYCLES(SC), .RESET_CODE(RC)
  ) dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .i_tune_val          (i_tune_val),
    .i_tune_code         (i_tune_code),
    .o_tune_rdy          (o_tune_rdy),
    .o_dig_afe_ring_tune (o_dig_afe_ring_tune),
    .o_afe_ring_tune_val (o_afe_ring_tune_val),
    .i_afe_ring_tune_rdy (i_afe_ring_tune_rdy),
    .o_tune_done         (o_tune_done),
    .o_state_mon         (o_state_mon)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it to completion. The AFE accepts each write
  // after a random stall in [stall_min, stall_max] cycles. With inject set, a
  // bogus request is driven every SETTLE cycle and must be ignored.
  task automatic do_request(input int code, input int stall_min, input int stall_max, input bit inject);
    int     exp_q[$];
    int     c, k, next_evt, held, stall, writes, n_exp, budget, waited;
    bit     in_write, finished;
    logic [W-1:0] held_code;

    c = model_cur;
    while (c != code) begin
      if (code > c) c += ((code - c) > MS) ? MS : (code - c);
      else          c -= ((c - code) > MS) ? MS : (c - code);
      exp_q.push_back(c);
    end
    n_exp = exp_q.size();

    waited = 0;
    do begin
      @(negedge i_clk);
      waited++;
    end while (!o_tune_rdy && waited < 50);
    check("rdy_before_req", 32'(o_tune_rdy), 1);

    i_afe_ring_tune_rdy = 1'b0;
    i_tune_val  = 1'b1;
    i_tune_code = W'(code);
    @(posedge i_clk);
    #1;
    i_tune_val  = 1'b0;
    i_tune_code = W'($urandom);

    k = 0; next_evt = 1; writes = 0; held = 0; stall = 0;
    in_write = 1'b0; finished = 1'b0; held_code = '0;
    budget = (n_exp + 1) * (SC + stall_max + 4) + 10;
    while (!finished && k < budget) begin
      @(negedge i_clk);
      k++;
      i_tune_val = 1'b0;
      if (o_afe_ring_tune_val) begin
        if (!in_write) begin
          check("write_timing", k, next_evt);
          check("write_code", 32'(o_dig_afe_ring_tune), (exp_q.size() > 0) ? exp_q[0] : 32'hFFFF_FFFF);
          held_code = o_dig_afe_ring_tune;
          in_write  = 1'b1;
          held      = 0;
          stall     = $urandom_range(stall_max, stall_min);
        end else begin
          check("write_stable", 32'(o_dig_afe_ring_tune), 32'(held_code));
          held++;
        end
        i_afe_ring_tune_rdy = (held == stall);
        if (held == stall) begin
          writes++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          in_write = 1'b0;
          next_evt = k + SC + 1;
        end
      end else begin
        i_afe_ring_tune_rdy = 1'($urandom_range(0, 1));
      end
      if (o_tune_done) begin
        check("done_timing", k, next_evt);
        check("done_code", 32'(o_dig_afe_ring_tune), code);
        finished = 1'b1;
      end
      if (inject && o_state_mon == SETTLE) begin
        check("rdy_low_busy", 32'(o_tune_rdy), 0);
        i_tune_val  = 1'b1;
        i_tune_code = W'($urandom);
      end
    end
    i_tune_val = 1'b0;
    check("finished_in_budget", 32'(finished), 1);
    check("write_count", writes, n_exp);

    @(negedge i_clk);
    check("done_single", 32'(o_tune_done), 0);
    check("rdy_after_done", 32'(o_tune_rdy), 1);
    check("idle_after_done", 32'(o_state_mon), 32'(IDLE));
    check("code_held", 32'(o_dig_afe_ring_tune), code);
    model_cur = code;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    i_rst_n = 1'b0;
    i_tune_val = 1'b0;
    i_tune_code = '0;
    i_afe_ring_tune_rdy = 1'b0;
    #2;
    check("rst_rdy", 32'(o_tune_rdy), 0);
    check("rst_val", 32'(o_afe_ring_tune_val), 0);
    check("rst_done", 32'(o_tune_done), 0);
    check("rst_code", 32'(o_dig_afe_ring_tune), RC);
    check("rst_state", 32'(o_state_mon), 32'(IDLE));
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("post_rst_rdy", 32'(o_tune_rdy), 1);

    do_request(10, 0, 0, 1'b0);   // 4, 8, 10
    do_request(3, 0, 0, 1'b0);    // 6, 3
    do_request(3, 0, 0, 1'b0);    // equal target
    do_request(10, 0, 0, 1'b0);
    do_request(10, 0, 0, 1'b0);   // equal target
    do_request(0, 0, 0, 1'b0);
    do_request(10, 0, 0, 1'b1);   // ignored requests during SETTLE
    do_request(30, 5, 5, 1'b0);   // AFE stalls 5 cycles per write
    do_request(255, 0, 1, 1'b0);  // full scale up
    do_request(0, 0, 1, 1'b0);    // full scale down

    // Reset in the middle of SETTLE at code 8.
    i_tune_val = 1'b1;
    i_tune_code = W'(10);
    i_afe_ring_tune_rdy = 1'b1;
    @(posedge i_clk);
    #1;
    i_tune_val = 1'b0;
    waited = 0;
    do begin
      @(negedge i_clk);
      waited++;
    end while (!(o_state_mon == SETTLE && o_dig_afe_ring_tune == W'(8)) && waited < 100);
    check("reach_settle_8", 32'(o_dig_afe_ring_tune), 8);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("abort_code", 32'(o_dig_afe_ring_tune), RC);
    check("abort_val", 32'(o_afe_ring_tune_val), 0);
    check("abort_rdy", 32'(o_tune_rdy), 0);
    check("abort_state", 32'(o_state_mon), 32'(IDLE));
    repeat (3) begin
      @(negedge i_clk);
      check("abort_no_done", 32'(o_tune_done), 0);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("release_rdy", 32'(o_tune_rdy), 1);
    check("release_state", 32'(o_state_mon), 32'(IDLE));
    check("release_code", 32'(o_dig_afe_ring_tune), RC);
    model_cur = RC;

    for (int i = 0; i < 15; i++) begin
      int smax;
      smax = $urandom_range(0, 3);
      do_request($urandom_range(0, 255), 0, smax, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tuner_dac_slew_ctrl.md
TUNER_DAC_SLEW_CTRL -- requirements
Module: tuner_dac_slew_ctrl

Interface
REQ-001 Parameter DAC_WIDTH, default 8, ring-tune DAC code width.
REQ-002 Parameter MAX_STEP, default 4, max code change per AFE transaction; SHALL be 1..2^DAC_WIDTH-1.
REQ-003 Parameter SETTLE_CYCLES, default 8, wait cycles after each accepted AFE write; SHALL be >=1.
REQ-004 Parameter RESET_CODE, default 0, DAC code held after reset.
REQ-005 i_clk  input  1  sole clock; all state on rising edge.
REQ-006 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 i_tune_val  input  1  upstream request valid (driven by ctrl arbitration stage).
REQ-008 i_tune_code  input  DAC_WIDTH  requested target code.
REQ-009 o_tune_rdy  output  1  block can accept a request.
REQ-010 o_dig_afe_ring_tune  output  DAC_WIDTH  code presented to AFE DAC.
REQ-011 o_afe_ring_tune_val  output  1  AFE write valid.
REQ-012 i_afe_ring_tune_rdy  input  1  AFE accepts write.
REQ-013 o_tune_done  output  1  one-cycle pulse: target reached and settled.
REQ-014 o_state_mon  output  tuner_dac_slew_state_e  current FSM state.

Function
REQ-015 FSM states SHALL be IDLE, STEP, SETTLE, DONE.
REQ-016 o_tune_rdy SHALL be 1 only in IDLE; request accepted on cycle with i_tune_val & o_tune_rdy; target latched that edge.
REQ-017 On accept: target == current code -> DONE next cycle, no AFE transaction; else -> STEP.
REQ-018 In STEP: next = current + min(target-current, MAX_STEP) if target > current, else current - min(current-target, MAX_STEP); unsigned, no wrap, never overshoots target.
REQ-019 In STEP o_afe_ring_tune_val SHALL be 1 and o_dig_afe_ring_tune = next, both stable until i_afe_ring_tune_rdy sampled 1.
REQ-020 On STEP with i_afe_ring_tune_rdy=1: current <= next, counter <= SETTLE_CYCLES-1, -> SETTLE.
REQ-021 Outside STEP o_afe_ring_tune_val SHALL be 0 and o_dig_afe_ring_tune = current code.
REQ-022 In SETTLE: counter decrements each cycle; at counter==0, -> DONE if current == target, else -> STEP.
REQ-023 In DONE: o_tune_done = 1 for exactly that cycle, -> IDLE next cycle.
REQ-024 i_tune_val/i_tune_code while not IDLE SHALL be ignored (not latched, no effect).
REQ-025 Latency, equal target: accept -> done pulse 1 cycle later. Per step with AFE rdy held 1: 1 STEP cycle + SETTLE_CYCLES cycles.
REQ-026 Number of AFE transactions for a request SHALL be ceil(|target-current|/MAX_STEP).
REQ-027 Full-scale moves (0 -> 2^DAC_WIDTH-1 and reverse) SHALL use DAC_WIDTH+1-bit or compare-based arithmetic; no overflow.

Reset
REQ-028 While i_rst_n=0: state IDLE, current = RESET_CODE, target = RESET_CODE, counter 0, o_tune_rdy 1 (after deassert), o_afe_ring_tune_val 0, o_tune_done 0, o_dig_afe_ring_tune = RESET_CODE.
REQ-029 Reset asserted mid-STEP or mid-SETTLE SHALL abort immediately; pending AFE valid drops asynchronously; no done pulse.
REQ-030 o_tune_rdy SHALL be 0 while i_rst_n=0.

Structure
REQ-031 Enum tuner_dac_slew_state_e (IDLE, STEP, SETTLE, DONE) SHALL live in tuner_phy_pkg.
REQ-032 Block is single module, no sub-modules; step computation is combinational inside it.
REQ-033 Block SHALL sit between ctrl arbitration PHY output and AFE DAC, replacing its direct AFE handshake.

Verification
REQ-034 Defaults, reset, request 0 -> 10, AFE rdy=1: writes 4, 8, 10; each val high 1 cycle; 8 settle cycles apart; one done pulse after last settle.
REQ-035 Current 10, request 3: writes 6, 3; no undershoot below 3; done pulse once.
REQ-036 Current 10, request 10: no AFE val; done pulse cycle after accept; rdy back next cycle.
REQ-037 AFE rdy held 0 for 5 cycles in STEP: val and code stable all 5 cycles; advance on first rdy=1 cycle.
REQ-038 New request 200 driven during SETTLE of request 0 -> 10: ignored; final code 10; rdy only after done.
REQ-039 i_rst_n pulled low mid-SETTLE at code 8: outputs immediately RESET_CODE, val 0, no done; after release, IDLE with rdy 1.
